multi_slot_recorder: RTL and testbench
======================================

MULTI_SLOT_RECORDER -- requirements
Module: multi_slot_recorder

Interface
REQ-001 SLOTS, 4, number of independent recording slots (>=2).
REQ-002 DEPTH, 1024, samples per slot.
REQ-003 SAMPLE_W, 8, stored sample width; DECIM = 2**SAMPLE_W clocks per sample period.
REQ-004 clock  input  1  single system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 slot_sel  input  $clog2(SLOTS)  slot chosen at record/play acceptance.
REQ-007 record  input  1  one-cycle start-record pulse (debounced upstream).
REQ-008 play  input  1  one-cycle start-play pulse.
REQ-009 stop  input  1  one-cycle stop pulse.
REQ-010 loop  input  1  level; when 1, playback restarts at end of slot.
REQ-011 microphone  input  1  PDM bit stream, sampled every clock.
REQ-012 audio_out  output  1  PWM audio.
REQ-013 mode  output  2  current FSM state encoding.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 cur_slot  output  $clog2(SLOTS)  slot latched for current operation.
REQ-016 slot_valid  output  SLOTS  bit i high when slot i holds >=1 sample.
REQ-017 sample_idx  output  $clog2(DEPTH+1)  current record/play sample index, for display.
REQ-018 reject  output  1  one-cycle pulse when a play request is refused.

Function
REQ-019 FSM states IDLE, RECORD, FETCH, PLAY; mode encodes IDLE=0, RECORD=1, FETCH=2, PLAY=3.
REQ-020 IDLE + record: latch slot_sel into cur_slot, clear sample_idx, phase and ones counter; RECORD next cycle.
REQ-021 IDLE + play with slot_valid[slot_sel]=1: latch slot, sample_idx=0; FETCH next cycle.
REQ-022 IDLE + play with slot_valid[slot_sel]=0: stay IDLE, reject high exactly one cycle.
REQ-023 Simultaneous record and play in IDLE: record wins; no reject.
REQ-024 RECORD: phase counts 0..DECIM-1; ones counter adds microphone each cycle.
REQ-025 At phase DECIM-1: sample = min(ones + microphone, DECIM-1); written to mem[cur_slot*DEPTH + sample_idx]; sample_idx increments; ones cleared.
REQ-026 RECORD ends on stop (partial period discarded) or when sample_idx reaches DEPTH; length[cur_slot] = sample_idx; slot_valid[cur_slot] = (length != 0); IDLE next cycle.
REQ-027 Recording into a valid slot overwrites it; its length becomes the new count.
REQ-028 FETCH: one-cycle synchronous RAM read of sample_idx; PLAY next cycle with phase=0.
REQ-029 PLAY: audio_out = (phase < sample); next sample prefetched so consecutive periods are gapless.
REQ-030 At phase DECIM-1 of the last sample (sample_idx = length-1): loop=1 restarts at index 0 without gap; loop=0 goes IDLE.
REQ-031 stop in PLAY: IDLE next cycle, audio_out 0 from that cycle.
REQ-032 record/play pulses outside IDLE ignored; stop in IDLE/FETCH ignored.
REQ-033 audio_out is 0 in every state except PLAY.

Reset
REQ-034 On reset: state IDLE, audio_out 0, busy 0, mode 0, cur_slot 0, sample_idx 0, reject 0, slot_valid all 0, all lengths 0, phase/ones 0.
REQ-035 Reset mid-operation aborts immediately; RAM contents unspecified and unreachable until re-recorded.

Structure
REQ-036 Package recorder_pkg holds state enum rec_state_t and mode encodings.
REQ-037 Sub-module pdm_decimator (phase + saturating ones counter, sample_valid strobe); RAM inferred in top as SLOTS*DEPTH x SAMPLE_W.

Verification (SLOTS=4, DEPTH=8, SAMPLE_W=4, DECIM=16)
REQ-038 Reset asserted mid-PLAY -> same cycle audio_out=0, slot_valid=4'b0000, mode=0.
REQ-039 slot_sel=2, record, mic=1 for 48 cycles, stop -> slot_valid=4'b0100; play slot 2 -> audio_out high 15 of 16 cycles for 3 periods, then busy=0.
REQ-040 Record mic toggling 1010... one period -> stored 8; playback audio_out high exactly 8 of 16 cycles.
REQ-041 Record with no stop -> auto-stop after 128 cycles, sample_idx=8, busy falls.
REQ-042 Play empty slot 1 -> reject one cycle, mode stays 0; record+play same cycle -> mode=1, reject=0.
REQ-043 loop=1 play 2-sample slot -> continuous 32-cycle repeating PWM pattern until stop; stop -> audio_out=0 next cycle.

Source files
------------

// File: rtl/multi_slot_recorder_pkg.sv
// Shared definitions for the multi-slot PDM recorder.
// rec_state_t doubles as the externally visible mode encoding:
//   IDLE=0, RECORD=1, FETCH=2, PLAY=3.
package recorder_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_FETCH  = 2'd2,
    ST_PLAY   = 2'd3
  } rec_state_t;

  function automatic logic [MODE_W-1:0] mode_of(input rec_state_t s);
    return s;
  endfunction

endpackage

// File: rtl/multi_slot_recorder_if.sv
// Control/status bundle of the multi-slot recorder.
//   master: drives slot_sel, record, play, stop, loop, microphone
//   slave : drives audio_out, mode, busy, cur_slot, slot_valid,
//           sample_idx, reject
interface multi_slot_recorder_if
  import recorder_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int DEPTH = 1024
);
  localparam int SEL_W = $clog2(SLOTS);
  localparam int IDX_W = $clog2(DEPTH + 1);

  logic [SEL_W-1:0]  slot_sel;
  logic              record;
  logic              play;
  logic              stop;
  logic              loop;
  logic              microphone;
  logic              audio_out;
  logic [MODE_W-1:0] mode;
  logic              busy;
  logic [SEL_W-1:0]  cur_slot;
  logic [SLOTS-1:0]  slot_valid;
  logic [IDX_W-1:0]  sample_idx;
  logic              reject;

  modport master (
    output slot_sel, record, play, stop, loop, microphone,
    input  audio_out, mode, busy, cur_slot, slot_valid, sample_idx, reject
  );

  modport slave (
    input  slot_sel, record, play, stop, loop, microphone,
    output audio_out, mode, busy, cur_slot, slot_valid, sample_idx, reject
  );
endinterface

// File: rtl/multi_slot_recorder_pdm_decimator.sv
// PDM-to-PCM decimator: counts ones over 2**SAMPLE_W clocks.
//   clear        : reset phase and ones counter (wins over run)
//   run          : advance phase / accumulate mic this cycle
//   mic          : PDM input bit
//   phase        : position within the current sample period
//   sample       : saturated ones + mic, valid on the last phase
//   sample_valid : run and last phase of the period
module pdm_decimator #(
  parameter int SAMPLE_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                run,
  input  logic                mic,
  output logic [SAMPLE_W-1:0] phase,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid
);
  localparam logic [SAMPLE_W-1:0] LAST = '1;

  logic [SAMPLE_W-1:0] ones;

  // A full period of ones would need SAMPLE_W+1 bits; saturate instead.
  always_comb begin
    sample       = (ones == LAST) ? LAST : ones + SAMPLE_W'(mic);
    sample_valid = run && (phase == LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase <= '0;
      ones  <= '0;
    end else if (clear) begin
      phase <= '0;
      ones  <= '0;
    end else if (run) begin
      phase <= phase + SAMPLE_W'(1);
      ones  <= (phase == LAST) ? '0 : sample;
    end
  end
endmodule

// File: rtl/multi_slot_recorder.sv
// Multi-slot PDM audio recorder with PWM playback.
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : record/play/stop pulses, loop level, slot_sel and PDM
//                  microphone in; PWM audio_out, mode, busy, cur_slot,
//                  slot_valid, sample_idx and reject out.
// Samples live in one RAM of SLOTS*DEPTH words, slot-major.
module multi_slot_recorder
  import recorder_pkg::*;
#(
  parameter int SLOTS    = 4,
  parameter int DEPTH    = 1024,
  parameter int SAMPLE_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  multi_slot_recorder_if.slave   bus
);
  localparam int SEL_W  = $clog2(SLOTS);
  localparam int IDX_W  = $clog2(DEPTH + 1);
  localparam int ADDR_W = $clog2(SLOTS * DEPTH);
  localparam logic [SAMPLE_W-1:0] LAST_PHASE = '1;
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(DEPTH - 1);

  rec_state_t state_q, state_d;

  logic [SEL_W-1:0]    cur_slot;
  logic [IDX_W-1:0]    sample_idx;
  logic [SLOTS-1:0]    slot_valid;
  logic                reject_q;
  logic [IDX_W-1:0]    length [SLOTS];

  logic [SAMPLE_W-1:0] mem [SLOTS*DEPTH];
  logic [SAMPLE_W-1:0] play_sample;

  logic                dec_clear, dec_run, sample_valid;
  logic [SAMPLE_W-1:0] phase, sample;
  logic                wr_en, rd_en, play_last;
  logic [IDX_W-1:0]    ram_idx;
  logic [ADDR_W-1:0]   ram_addr;

  pdm_decimator #(.SAMPLE_W(SAMPLE_W)) u_dec (
    .clock        (clock),
    .reset        (reset),
    .clear        (dec_clear),
    .run          (dec_run),
    .mic          (bus.microphone),
    .phase        (phase),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  assign play_last = (sample_idx == length[cur_slot] - IDX_W'(1));
  assign ram_addr  = ADDR_W'(cur_slot) * ADDR_W'(DEPTH) + ADDR_W'(ram_idx);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Playback reads the next sample on the last phase of the current one,
  // so play_sample switches on the same edge the phase wraps (gapless).
  always_comb begin
    state_d   = state_q;
    dec_clear = 1'b0;
    dec_run   = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    ram_idx   = sample_idx;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.record) begin
          state_d   = ST_RECORD;
          dec_clear = 1'b1;
        end else if (bus.play && slot_valid[bus.slot_sel]) begin
          state_d = ST_FETCH;
        end
      end
      ST_RECORD: begin
        dec_run = 1'b1;
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (sample_valid) begin
          wr_en = 1'b1;
          if (sample_idx == LAST_IDX) state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_d   = ST_PLAY;
        rd_en     = 1'b1;
        dec_clear = 1'b1;
      end
      ST_PLAY: begin
        dec_run = 1'b1;
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (phase == LAST_PHASE) begin
          if (!play_last) begin
            rd_en   = 1'b1;
            ram_idx = sample_idx + IDX_W'(1);
          end else if (bus.loop) begin
            rd_en   = 1'b1;
            ram_idx = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_slot   <= '0;
      sample_idx <= '0;
      slot_valid <= '0;
      reject_q   <= 1'b0;
      for (int unsigned i = 0; i < SLOTS; i++) length[i] <= '0;
    end else begin
      reject_q <= (state_q == ST_IDLE) && bus.play && !bus.record &&
                  !slot_valid[bus.slot_sel];
      unique case (state_q)
        ST_IDLE: begin
          if (bus.record || (bus.play && slot_valid[bus.slot_sel])) begin
            cur_slot   <= bus.slot_sel;
            sample_idx <= '0;
          end
        end
        ST_RECORD: begin
          if (bus.stop) begin
            length[cur_slot]     <= sample_idx;
            slot_valid[cur_slot] <= (sample_idx != '0);
          end else if (sample_valid) begin
            sample_idx <= sample_idx + IDX_W'(1);
            if (sample_idx == LAST_IDX) begin
              length[cur_slot]     <= IDX_W'(DEPTH);
              slot_valid[cur_slot] <= 1'b1;
            end
          end
        end
        default: begin
          if (rd_en) sample_idx <= ram_idx;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[ram_addr] <= sample;
    if (rd_en) play_sample   <= mem[ram_addr];
  end

  assign bus.audio_out  = (state_q == ST_PLAY) && (phase < play_sample);
  assign bus.mode       = mode_of(state_q);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.cur_slot   = cur_slot;
  assign bus.slot_valid = slot_valid;
  assign bus.sample_idx = sample_idx;
  assign bus.reject     = reject_q;
endmodule

// File: tb/tb_multi_slot_recorder.sv
module tb_multi_slot_recorder;
  localparam int SLOTS    = 4;
  localparam int DEPTH    = 8;
  localparam int SAMPLE_W = 4;
  localparam int DECIM    = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multi_slot_recorder_if #(.SLOTS(SLOTS), .DEPTH(DEPTH)) bus ();

  multi_slot_recorder #(.SLOTS(SLOTS), .DEPTH(DEPTH), .SAMPLE_W(SAMPLE_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] bits;
    int          exp;
  } vec_t;

  vec_t vecs [9];
  int   tests = 0;
  int   fails = 0;
  int   exp_q [$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_record(input int slot);
    bus.slot_sel = 2'(slot);
    bus.record   = 1'b1;
    tick();
    bus.record   = 1'b0;
  endtask

  // bit p of the pattern is presented at phase p
  task automatic rec_period(input logic [15:0] bits);
    for (int p = 0; p < DECIM; p++) begin
      bus.microphone = bits[p];
      tick();
    end
    bus.microphone = 1'b0;
  endtask

  task automatic stop_pulse();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic start_play(input int slot);
    bus.slot_sel = 2'(slot);
    bus.play     = 1'b1;
    tick();
    bus.play     = 1'b0;
    tick();
  endtask

  // count audio_out highs per period and compare against the scoreboard
  task automatic play_periods(input int n, input string name, input bit recycle);
    int cnt;
    int e;
    for (int k = 0; k < n; k++) begin
      cnt = 0;
      for (int c = 0; c < DECIM; c++) begin
        if (bus.audio_out === 1'b1) cnt++;
        tick();
      end
      if (exp_q.size() == 0) begin
        check({name, "_queue_empty"}, 1, 0);
      end else begin
        e = exp_q.pop_front();
        if (recycle) exp_q.push_back(e);
        check(name, cnt, e);
      end
    end
  endtask

  initial begin
    int ones;
    int cyc;

    vecs[0] = '{16'hFFFF, 15};
    vecs[1] = '{16'h0000, 0};
    vecs[2] = '{16'hAAAA, 8};
    vecs[3] = '{16'h5555, 8};
    vecs[4] = '{16'h0001, 1};
    vecs[5] = '{16'h7FFF, 15};
    vecs[6] = '{16'hFFFE, 15};
    vecs[7] = '{16'h8000, 1};
    vecs[8] = '{16'h000F, 4};

    bus.slot_sel   = '0;
    bus.record     = 1'b0;
    bus.play       = 1'b0;
    bus.stop       = 1'b0;
    bus.loop       = 1'b0;
    bus.microphone = 1'b0;

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    check("rst_audio", bus.audio_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_mode", bus.mode, 0);
    check("rst_cur_slot", bus.cur_slot, 0);
    check("rst_sample_idx", bus.sample_idx, 0);
    check("rst_reject", bus.reject, 0);
    check("rst_slot_valid", bus.slot_valid, 0);

    stop_pulse();
    check("idle_stop_ignored", bus.mode, 0);

    bus.slot_sel = 2'd1;
    bus.play     = 1'b1;
    tick();
    bus.play     = 1'b0;
    check("reject_pulse", bus.reject, 1);
    check("reject_mode", bus.mode, 0);
    tick();
    check("reject_one_cycle", bus.reject, 0);

    bus.slot_sel = 2'd3;
    bus.record   = 1'b1;
    bus.play     = 1'b1;
    tick();
    bus.record   = 1'b0;
    bus.play     = 1'b0;
    check("rec_wins_mode", bus.mode, 1);
    check("rec_wins_reject", bus.reject, 0);
    check("rec_wins_slot", bus.cur_slot, 3);
    stop_pulse();
    check("empty_rec_valid", bus.slot_valid, 0);
    check("empty_rec_busy", bus.busy, 0);

    start_record(2);
    for (int i = 0; i < 3; i++) begin
      rec_period(16'hFFFF);
      exp_q.push_back(15);
    end
    stop_pulse();
    check("ones_slot_valid", bus.slot_valid, 4'b0100);
    check("ones_len", bus.sample_idx, 3);
    start_play(2);
    check("ones_play_mode", bus.mode, 3);
    check("ones_play_slot", bus.cur_slot, 2);
    play_periods(3, "ones_play", 1'b0);
    check("ones_done_busy", bus.busy, 0);
    check("ones_done_audio", bus.audio_out, 0);

    for (int i = 0; i < 9; i++) begin
      start_record(0);
      rec_period(vecs[i].bits);
      exp_q.push_back(vecs[i].exp);
      stop_pulse();
      check("tbl_len", bus.sample_idx, 1);
      start_play(0);
      play_periods(1, "tbl_play", 1'b0);
      check("tbl_done_busy", bus.busy, 0);
    end

    start_record(1);
    ones = 0;
    cyc  = 0;
    while (bus.busy && cyc < 200) begin
      bus.microphone = 1'($urandom_range(0, 1));
      bus.play       = (cyc == 40);
      bus.record     = (cyc == 41);
      ones += int'(bus.microphone);
      tick();
      cyc++;
      if (cyc == 41) check("rec_ignores_play", bus.mode, 1);
      if (cyc % DECIM == 0) begin
        exp_q.push_back(ones > 15 ? 15 : ones);
        ones = 0;
      end
    end
    bus.play       = 1'b0;
    bus.record     = 1'b0;
    bus.microphone = 1'b0;
    check("autostop_cycles", cyc, 128);
    check("autostop_idx", bus.sample_idx, 8);
    check("autostop_busy", bus.busy, 0);
    check("autostop_valid", bus.slot_valid, 4'b0111);
    if (cyc != 128) exp_q.delete();
    start_play(1);
    play_periods(8, "rand_play", 1'b0);
    check("rand_done_busy", bus.busy, 0);

    exp_q.delete();
    start_record(3);
    rec_period(16'h00FF);
    exp_q.push_back(8);
    rec_period(16'h000F);
    exp_q.push_back(4);
    stop_pulse();
    check("loop_slot_valid", bus.slot_valid, 4'b1111);
    bus.loop = 1'b1;
    start_play(3);
    for (int r = 0; r < 3; r++) begin
      play_periods(2, "loop_play", 1'b1);
      check("loop_still_playing", bus.mode, 3);
    end
    check("loop_audio_high", bus.audio_out, 1);
    stop_pulse();
    check("loop_stop_audio", bus.audio_out, 0);
    check("loop_stop_mode", bus.mode, 0);
    check("loop_stop_busy", bus.busy, 0);
    bus.loop = 1'b0;
    exp_q.delete();

    start_play(2);
    repeat (3) tick();
    check("pre_reset_audio", bus.audio_out, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_audio", bus.audio_out, 0);
    check("async_rst_valid", bus.slot_valid, 4'b0000);
    check("async_rst_mode", bus.mode, 0);
    check("async_rst_busy", bus.busy, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    bus.slot_sel = 2'd2;
    bus.play     = 1'b1;
    tick();
    bus.play     = 1'b0;
    check("post_rst_reject", bus.reject, 1);
    check("post_rst_mode", bus.mode, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end
endmodule
